// File: rtl/fixed_to_float_converter_pkg.sv
// sp_pkg: binary32 field widths, exponent bias and a field-packing helper.
// Shared by the fixed-to-float converter and its testbench.
package sp_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  // Assemble {sign, biased exponent, fraction} into a binary32 word.
  function automatic logic [31:0] pack_fp32(
    input logic                   sign,
    input logic [FP32_EXP_W-1:0]  biased_exp,
    input logic [FP32_FRAC_W-1:0] frac
  );
    return {sign, biased_exp, frac};
  endfunction

endpackage

// File: rtl/fixed_to_float_converter_if.sv
// fixed_to_float_converter_if: one valid/ready stream with a WIDTH-bit payload.
//   valid : producer has data this cycle
//   ready : consumer accepts data this cycle
//   data  : payload
// master = producer side, slave = consumer side.
interface fixed_to_float_converter_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fixed_to_float_converter_lzc.sv
// lzc: position of the most significant set bit of a WIDTH-bit word.
//   in   : word to scan
//   pos  : index of the leading one (0 when in is all zeros)
//   zero : in is all zeros
module lzc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     zero
);
  localparam int POS_W = $clog2(WIDTH);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|in;
endmodule

// File: rtl/fixed_to_float_converter.sv
// fixed_to_float_converter: signed fixed-point (Q_FACTOR fraction bits) to
// IEEE-754 binary32, three pipeline stages, 1 sample/cycle.
//   clk    : clock
//   reset  : synchronous, active-high; drops every in-flight sample
//   in_if  : slave stream, FIX_WIDTH-bit two's-complement samples
//   out_if : master stream, 32-bit binary32 results
// All stages move together on adv = !out_valid || out_ready (global stall),
// and in_ready is that same enable.
module fixed_to_float_converter
  import sp_pkg::*;
#(
  parameter int FIX_WIDTH = 16,
  parameter int Q_FACTOR  = 8
) (
  input  logic clk,
  input  logic reset,
  fixed_to_float_converter_if.slave  in_if,
  fixed_to_float_converter_if.master out_if
);
  localparam int POS_W = $clog2(FIX_WIDTH);

  logic adv;
  logic out_valid_reg;
  logic [31:0] out_data_reg;

  assign adv          = !out_valid_reg || out_if.ready;
  assign in_if.ready  = adv;
  assign out_if.valid = out_valid_reg;
  assign out_if.data  = out_data_reg;

  // ---------------- S1: sign / magnitude / zero ----------------
  logic                 in_sign;
  logic [FIX_WIDTH-1:0] in_mag;
  logic                 s1_valid_reg, s1_sign_reg, s1_zero_reg;
  logic [FIX_WIDTH-1:0] s1_mag_reg;

  // Negating the most negative code wraps back to 100..0, which read as
  // unsigned is exactly 2^(FIX_WIDTH-1).
  assign in_sign = in_if.data[FIX_WIDTH-1];
  assign in_mag  = in_sign ? (~in_if.data) + FIX_WIDTH'(1) : in_if.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_zero_reg  <= 1'b0;
      s1_mag_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_if.valid;
      s1_sign_reg  <= in_sign;
      s1_zero_reg  <= (in_if.data == '0);
      s1_mag_reg   <= in_mag;
    end
  end

  // ---------------- S2: normalise ----------------
  logic [POS_W-1:0] lz_pos;
  logic             lz_zero;
  logic [5:0]       shamt;
  logic [31:0]      norm_next;
  logic             s2_valid_reg, s2_sign_reg, s2_zero_reg;
  logic [POS_W-1:0] s2_pos_reg;
  logic [31:0]      s2_norm_reg;

  lzc #(.WIDTH(FIX_WIDTH)) u_lzc (
    .in   (s1_mag_reg),
    .pos  (lz_pos),
    .zero (lz_zero)
  );

  // Shift by one more than needed so the leading one falls off the top:
  // norm[31:9] is the fraction, norm[8] the guard bit, norm[7:0] sticky.
  assign shamt     = lz_zero ? 6'd0 : 6'(32 - int'(lz_pos));
  assign norm_next = 32'(s1_mag_reg) << shamt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_zero_reg  <= 1'b0;
      s2_pos_reg   <= '0;
      s2_norm_reg  <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_zero_reg  <= s1_zero_reg;
      s2_pos_reg   <= lz_pos;
      s2_norm_reg  <= norm_next;
    end
  end

  // ---------------- S3: exponent, round to nearest even ----------------
  logic [FP32_FRAC_W-1:0] frac;
  logic [FP32_FRAC_W:0]   frac_rnd;
  logic [FP32_EXP_W-1:0]  exp_base, exp_fin;
  logic                   guard, sticky, round_up;
  logic [31:0]            result;

  always_comb begin
    frac     = s2_norm_reg[31:9];
    guard    = s2_norm_reg[8];
    sticky   = |s2_norm_reg[7:0];
    round_up = guard && (sticky || frac[0]);
    frac_rnd = {1'b0, frac} + (FP32_FRAC_W+1)'(round_up);
    exp_base = FP32_EXP_W'(FP32_BIAS - Q_FACTOR + int'(s2_pos_reg));
    // Carry out of the mantissa leaves frac_rnd[22:0] all zero; bump exponent.
    exp_fin  = exp_base + FP32_EXP_W'(frac_rnd[FP32_FRAC_W]);
    result   = s2_zero_reg ? 32'h0000_0000
                           : pack_fp32(s2_sign_reg, exp_fin, frac_rnd[FP32_FRAC_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (adv) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) out_data_reg <= result;
    end
  end
endmodule

// File: tb/tb_fixed_to_float_converter.sv
// Scoreboard bench: dut 0 is FIX_WIDTH=16/Q=8, dut 1 is FIX_WIDTH=32/Q=0.
// The driver pushes expected words on acceptance; the monitor pops and
// compares on every output transfer, and watches stall behaviour.
module tb_fixed_to_float_converter;

  typedef struct {
    logic [31:0] d;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  fixed_to_float_converter_if #(.WIDTH(16)) a_in ();
  fixed_to_float_converter_if #(.WIDTH(32)) a_out ();
  fixed_to_float_converter_if #(.WIDTH(32)) b_in ();
  fixed_to_float_converter_if #(.WIDTH(32)) b_out ();

  fixed_to_float_converter #(.FIX_WIDTH(16), .Q_FACTOR(8)) u_dut_a (
    .clk(clk), .reset(reset), .in_if(a_in), .out_if(a_out));
  fixed_to_float_converter #(.FIX_WIDTH(32), .Q_FACTOR(0)) u_dut_b (
    .clk(clk), .reset(reset), .in_if(b_in), .out_if(b_out));

  logic        drv_valid [2];
  logic        drv_ready [2];
  logic [15:0] data_a;
  logic [31:0] data_b;
  logic        obs_in_ready [2];
  logic        obs_valid [2];
  logic [31:0] obs_data [2];

  assign a_in.valid  = drv_valid[0];
  assign a_in.data   = data_a;
  assign a_out.ready = drv_ready[0];
  assign b_in.valid  = drv_valid[1];
  assign b_in.data   = data_b;
  assign b_out.ready = drv_ready[1];
  assign obs_in_ready[0] = a_in.ready;
  assign obs_in_ready[1] = b_in.ready;
  assign obs_valid[0]    = a_out.valid;
  assign obs_valid[1]    = b_out.valid;
  assign obs_data[0]     = a_out.data;
  assign obs_data[1]     = b_out.data;

  exp_t exp_q [2][$];
  int   mode [2];          // 0 ready=1, 1 random, 2 stall cycles 4..9, 3 ready=0
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pushed [2];
  int   popped [2];
  int   stall_seen [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Independent reference: exact double, then round-to-nearest-even to 24 bits.
  function automatic logic [31:0] ref_fp(input int v, input int q);
    real         r;
    logic [63:0] d;
    logic [52:0] m;
    logic [23:0] hi;
    int          e;
    if (v == 0) return 32'h0;
    r  = $itor(v) / (2.0 ** q);
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023;
    m  = {1'b1, d[51:0]};
    hi = m[52:29];
    if (m[28] && ((|m[27:0]) || hi[0])) begin
      if (hi == 24'hFFFFFF) begin
        hi = 24'h800000;
        e++;
      end else begin
        hi = hi + 24'd1;
      end
    end
    return {d[63], 8'(e + 127), hi[22:0]};
  endfunction

  initial forever @(posedge clk) cyc++;

  // out_ready generator, changes well away from both clock edges.
  initial begin
    int bp_cyc [2];
    bp_cyc = '{0, 0};
    drv_ready = '{1'b1, 1'b1};
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (mode[i] == 2) bp_cyc[i]++;
        else bp_cyc[i] = 0;
        case (mode[i])
          1:       drv_ready[i] = ($urandom_range(0, 3) != 0);
          2:       drv_ready[i] = !(bp_cyc[i] >= 4 && bp_cyc[i] <= 9);
          3:       drv_ready[i] = 1'b0;
          default: drv_ready[i] = 1'b1;
        endcase
      end
    end
  end

  // Monitor: sampled on the falling edge.
  initial begin
    bit          was_stall [2];
    logic [31:0] held [2];
    exp_t        e;
    was_stall = '{0, 0};
    held      = '{32'h0, 32'h0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          was_stall[i] = 0;
          continue;
        end
        if (was_stall[i]) begin
          chk($sformatf("hold_valid dut%0d", i), 32'(obs_valid[i]), 32'd1);
          chk($sformatf("hold_data dut%0d", i), obs_data[i], held[i]);
        end
        if (obs_valid[i] && !drv_ready[i]) begin
          stall_seen[i]++;
          chk($sformatf("stall_in_ready dut%0d", i), 32'(obs_in_ready[i]), 32'd0);
        end
        if (obs_valid[i] && drv_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d actual=%h required=no output", i, obs_data[i]);
          end else begin
            e = exp_q[i].pop_front();
            popped[i]++;
            $display("dut%0d out %h expect %h", i, obs_data[i], e.d);
            chk($sformatf("out_data dut%0d", i), obs_data[i], e.d);
            // Rising edges from the accepting edge (inclusive) to the one
            // that raised out_valid.
            if (e.lat && mode[i] == 0)
              chk($sformatf("latency dut%0d", i), 32'(cyc - e.acc + 1), 32'd3);
          end
        end
        was_stall[i] = obs_valid[i] && !drv_ready[i];
        held[i]      = obs_data[i];
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input int d, input logic [31:0] x, input logic [31:0] expv);
    int   t;
    exp_t e;
    drv_valid[d] = 1'b1;
    if (d == 0) data_a = x[15:0];
    else        data_b = x;
    t = 0;
    while (!obs_in_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!obs_in_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d actual=in_ready 0 required=1", d);
      drv_valid[d] = 1'b0;
      return;
    end
    e.d   = expv;
    e.acc = cyc + 1;
    e.lat = (mode[d] == 0);
    exp_q[d].push_back(e);
    pushed[d]++;
    $display("dut%0d in %h expect %h", d, x, expv);
    @(negedge clk);
    drv_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (exp_q[d].size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_left dut%0d", d), 32'(exp_q[d].size()), 32'd0);
    exp_q[d].delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [15:0] x16;
    drv_valid  = '{1'b0, 1'b0};
    data_a     = '0;
    data_b     = '0;
    mode       = '{0, 0};
    pushed     = '{0, 0};
    popped     = '{0, 0};
    stall_seen = '{0, 0};
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_out_valid dut%0d", i), 32'(obs_valid[i]), 32'd0);
      chk($sformatf("reset_out_data dut%0d", i), obs_data[i], 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("post_reset_in_ready dut%0d", i), 32'(obs_in_ready[i]), 32'd1);

    // Basic values, back-to-back.
    send(0, 32'h0100, 32'h3F800000);
    send(0, 32'hFF00, 32'hBF800000);
    send(0, 32'h0000, 32'h00000000);
    send(0, 32'h0001, 32'h3B800000);
    drain(0);
    // 16-bit extremes.
    send(0, 32'h7FFF, 32'h42FFFE00);
    send(0, 32'h8000, 32'hC3000000);
    drain(0);
    // 32-bit rounding and extremes.
    send(1, 32'h01000001, 32'h4B800000);
    send(1, 32'h01000003, 32'h4B800002);
    send(1, 32'h7FFFFFFF, 32'h4F000000);
    send(1, 32'h80000000, 32'hCF000000);
    send(1, 32'h00000001, 32'h3F800000);
    send(1, 32'hFFFFFFFF, 32'hBF800000);
    drain(1);

    // Backpressure: 8 samples, out_ready low for cycles 4..9.
    mode[0] = 2;
    for (int k = 1; k <= 8; k++) begin
      case (k)
        1: send(0, 32'h0100, 32'h3F800000);
        2: send(0, 32'h0200, 32'h40000000);
        3: send(0, 32'h0300, 32'h40400000);
        4: send(0, 32'h0400, 32'h40800000);
        5: send(0, 32'h0500, 32'h40A00000);
        6: send(0, 32'h0600, 32'h40C00000);
        7: send(0, 32'h0700, 32'h40E00000);
        default: send(0, 32'h0800, 32'h41000000);
      endcase
    end
    drain(0);
    chk("backpressure_stall_seen", 32'(stall_seen[0] > 0), 32'd1);
    mode[0] = 0;
    repeat (2) @(negedge clk);

    // Reset with three samples in flight (output held by out_ready=0).
    mode[0] = 3;
    send(0, 32'h0200, 32'h40000000);
    send(0, 32'h0300, 32'h40400000);
    send(0, 32'h0400, 32'h40800000);
    chk("inflight_out_valid", 32'(obs_valid[0]), 32'd1);
    reset = 1'b1;
    pushed[0] = pushed[0] - exp_q[0].size();
    exp_q[0].delete();
    @(negedge clk);
    chk("reset_flush_out_valid", 32'(obs_valid[0]), 32'd0);
    mode[0] = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'(obs_valid[0]), 32'd0);
    end
    send(0, 32'hFE80, 32'hBFC00000);
    drain(0);

    // Random data with random in_valid gaps and random out_ready.
    for (int d = 0; d < 2; d++) begin
      mode[d] = 1;
      for (int n = 0; n < 300; n++) begin
        x = $urandom;
        if (d == 0) begin
          x16 = x[15:0];
          send(0, {16'h0, x16}, ref_fp(int'($signed(x16)), 8));
        end else begin
          send(1, x, ref_fp(int'($signed(x)), 0));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(d);
      mode[d] = 0;
    end

    for (int i = 0; i < 2; i++)
      chk($sformatf("transfer_count dut%0d", i), 32'(popped[i]), 32'(pushed[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
